// File: rtl/mrv32_pkg.sv
// mrv32 execute-unit shared types: ALU opcodes, multi-cycle FSM states and
// opcode classification helpers used by the ALU top and the mul/div datapath.
package mrv32_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIN  = 3'd3,
    ST_WAIT = 3'd4
  } mc_state_e;

  // MUL, MULH, MULHSU, MULHU
  function automatic logic op_is_mul(input logic [4:0] op);
    return (op[4:2] == 3'b100);
  endfunction

  // DIV, DIVU, REM, REMU
  function automatic logic op_is_div(input logic [4:0] op);
    return (op[4:2] == 3'b101);
  endfunction

  // Operand 1 is interpreted as two's complement for these ops.
  function automatic logic op1_signed(input logic [4:0] op);
    logic s;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: s = 1'b1;
      default:                                          s = 1'b0;
    endcase
    return s;
  endfunction

  // Operand 2 is interpreted as two's complement for these ops.
  function automatic logic op2_signed(input logic [4:0] op);
    logic s;
    case (op)
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: s = 1'b1;
      default:                             s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mrv32_muldiv_iter.sv
// Shared radix-2 iteration datapath for unsigned magnitudes.
// Multiply: acc = {hi, lo}, lo starts as the multiplier; shift-add each step.
// Divide:   acc = {rem, quo}, quo starts as the dividend; restoring step.
// opa holds the multiplicand (multiply) or the divisor (divide).
module mrv32_muldiv_iter
  import mrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill_i,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] acc_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0]     cnt_q;
  logic              is_div_q;
  logic [XLEN-1:0]   opa_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;

  // One iteration step of either shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
    div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opa_q};
    if (is_div_q) begin
      if (!div_diff_s[XLEN]) begin
        acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Operand load on start, then XLEN iterations counted down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= CNT_ZERO;
      is_div_q <= 1'b0;
      opa_q    <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
    end else if (kill_i) begin
      cnt_q    <= CNT_ZERO;
    end else if (start_i) begin
      cnt_q    <= CNT_INIT;
      is_div_q <= is_div_i;
      opa_q    <= opa_i;
      acc_q    <= {{XLEN{1'b0}}, opb_i};
    end else if (cnt_q != CNT_ZERO) begin
      cnt_q    <= cnt_q - CNT_ONE;
      acc_q    <= acc_d;
    end else begin
      cnt_q    <= cnt_q;
    end
  end

  // Last iteration is being performed in this cycle.
  assign done_o = (cnt_q == CNT_ONE);
  assign acc_o  = acc_q;

endmodule

// File: rtl/mrv32_alu_mc.sv
// mrv32 multi-cycle execute unit: single-cycle integer ALU ops, division
// fast paths, and iterative MUL*/DIV*/REM* behind a valid/ready handshake,
// with a registered output stage and a pass-through tag.
module mrv32_alu_mc
  import mrv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mc_state_e         state_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_result_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [TAG_W-1:0]  tag_q;
  logic [4:0]        op_q;
  logic              neg_q;
  logic              rem_neg_q;

  logic              out_free_s;
  logic              accept_s;
  logic              is_mul_s;
  logic              is_div_s;
  logic              op1_neg_s;
  logic              op2_neg_s;
  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              iter_start_s;
  logic [SHW-1:0]    shamt_s;
  logic              iter_done_s;
  logic [2*XLEN-1:0] acc_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   alu_result_d;
  logic [XLEN-1:0]   fin_result_d;

  // Handshake and operand classification for the request on the input pins.
  always_comb begin
    out_free_s   = !out_valid_q || out_ready;
    in_ready     = (state_q == ST_IDLE) && out_free_s;
    accept_s     = in_valid && in_ready;
    is_mul_s     = op_is_mul(in_op);
    is_div_s     = op_is_div(in_op);
    op1_neg_s    = op1_signed(in_op) && in_op1[XLEN-1];
    op2_neg_s    = op2_signed(in_op) && in_op2[XLEN-1];
    mag1_s       = op1_neg_s ? (ZERO - in_op1) : in_op1;
    mag2_s       = op2_neg_s ? (ZERO - in_op2) : in_op2;
    div_zero_s   = (in_op2 == ZERO);
    div_ovf_s    = op1_signed(in_op) && (in_op1 == SMIN) && (in_op2 == ONES);
    iter_start_s = accept_s && !flush
                 && (is_mul_s || (is_div_s && !div_zero_s && !div_ovf_s));
    shamt_s      = in_op2[SHW-1:0];
  end

  // Single-cycle results, including the division fast paths.
  always_comb begin
    alu_result_d = ZERO;
    case (in_op)
      ALU_ADD:  alu_result_d = in_op1 + in_op2;
      ALU_SUB:  alu_result_d = in_op1 - in_op2;
      ALU_AND:  alu_result_d = in_op1 & in_op2;
      ALU_OR:   alu_result_d = in_op1 | in_op2;
      ALU_XOR:  alu_result_d = in_op1 ^ in_op2;
      ALU_SLL:  alu_result_d = in_op1 << shamt_s;
      ALU_SRL:  alu_result_d = in_op1 >> shamt_s;
      ALU_SRA:  alu_result_d = $unsigned($signed(in_op1) >>> shamt_s);
      ALU_SLT:  alu_result_d = {{(XLEN-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
      ALU_SLTU: alu_result_d = {{(XLEN-1){1'b0}}, (in_op1 < in_op2)};
      ALU_DIV, ALU_DIVU: begin
        if (div_zero_s) begin
          alu_result_d = ONES;
        end else if (div_ovf_s) begin
          alu_result_d = SMIN;
        end else begin
          alu_result_d = ZERO;
        end
      end
      ALU_REM, ALU_REMU: begin
        if (div_zero_s) begin
          alu_result_d = in_op1;
        end else begin
          alu_result_d = ZERO;
        end
      end
      default:  alu_result_d = ZERO;
    endcase
  end

  mrv32_muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (flush),
    .start_i  (iter_start_s),
    .is_div_i (is_div_s),
    .opa_i    (is_div_s ? mag2_s : mag1_s),
    .opb_i    (is_div_s ? mag1_s : mag2_s),
    .done_o   (iter_done_s),
    .acc_o    (acc_s)
  );

  // Sign correction and half selection of the iterative result.
  always_comb begin
    prod_s       = neg_q ? ({(2*XLEN){1'b0}} - acc_s) : acc_s;
    fin_result_d = ZERO;
    case (op_q)
      ALU_MUL:                          fin_result_d = prod_s[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  fin_result_d = prod_s[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU: fin_result_d = neg_q ? (ZERO - acc_s[XLEN-1:0]) : acc_s[XLEN-1:0];
      ALU_REM, ALU_REMU: fin_result_d = rem_neg_q ? (ZERO - acc_s[2*XLEN-1:XLEN])
                                                  : acc_s[2*XLEN-1:XLEN];
      default:                          fin_result_d = ZERO;
    endcase
  end

  // Control FSM with the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= ZERO;
      out_tag_q    <= {TAG_W{1'b0}};
      tag_q        <= {TAG_W{1'b0}};
      op_q         <= 5'd0;
      neg_q        <= 1'b0;
      rem_neg_q    <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            tag_q     <= in_tag;
            op_q      <= in_op;
            neg_q     <= op1_neg_s ^ op2_neg_s;
            rem_neg_q <= op1_neg_s;
            if (iter_start_s) begin
              state_q <= is_mul_s ? ST_MUL : ST_DIV;
            end else begin
              out_valid_q  <= 1'b1;
              out_result_q <= alu_result_d;
              out_tag_q    <= in_tag;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_done_s) begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN, ST_WAIT: begin
          if (out_free_s) begin
            out_valid_q  <= 1'b1;
            out_result_q <= fin_result_d;
            out_tag_q    <= tag_q;
            state_q      <= ST_IDLE;
          end else begin
            state_q      <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_mrv32_alu_mc.sv
// Self-checking bench for mrv32_alu_mc (XLEN=32): vector table plus
// hand-written multi-cycle sequences; results checked through a scoreboard.
module tb_mrv32_alu_mc;
  import mrv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  in_op;
  logic [31:0] in_op1, in_op2, out_result;
  logic [4:0]  in_tag, out_tag;

  int n_chk = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mrv32_alu_mc #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got tag %0d result 0x%0h, want no output", out_tag, out_result);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk($sformatf("result_tag%0d", e[36:32]), {27'd0, out_tag, out_result}, {27'd0, e});
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit expect_out, input logic [31:0] res);
    int g = 0;
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_chk++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0, want 1 within 100 cycles");
    end
    @(posedge clk);
    if (expect_out) exp_q.push_back({tag, res});
    #1;
    in_valid = 1'b0;
    in_op1 = $urandom;
    in_op2 = $urandom;
    in_tag = 5'($urandom);
    @(negedge clk);
  endtask

  // Counts cycles from the accept edge until out_valid is seen.
  task automatic wait_out(input string name, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 5'd0; in_op1 = 32'd0; in_op2 = 32'd0; in_tag = 5'd0;

    tbl.push_back('{ALU_ADD,    32'd5,        32'd7,        32'd12,       1});
    tbl.push_back('{ALU_SUB,    32'd3,        32'd5,        32'hFFFFFFFE, 1});
    tbl.push_back('{ALU_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
    tbl.push_back('{ALU_OR,     32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1});
    tbl.push_back('{ALU_XOR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1});
    tbl.push_back('{ALU_SLL,    32'd1,        32'h21,       32'd2,        1});
    tbl.push_back('{ALU_SRL,    32'h80000000, 32'd31,       32'd1,        1});
    tbl.push_back('{ALU_SRA,    32'h80000000, 32'h24,       32'hF8000000, 1});
    tbl.push_back('{ALU_SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        1});
    tbl.push_back('{ALU_SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        1});
    tbl.push_back('{5'd10,      32'd5,        32'd7,        32'd0,        1});
    tbl.push_back('{5'd27,      32'd5,        32'd7,        32'd0,        1});
    tbl.push_back('{ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34});
    tbl.push_back('{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
    tbl.push_back('{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    tbl.push_back('{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    tbl.push_back('{ALU_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34});
    tbl.push_back('{ALU_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 34});
    tbl.push_back('{ALU_MULHU,  32'h80000000, 32'd4,        32'd2,        34});
    tbl.push_back('{ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    tbl.push_back('{ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    tbl.push_back('{ALU_DIVU,   32'd100,      32'd7,        32'd14,       34});
    tbl.push_back('{ALU_REMU,   32'd100,      32'd7,        32'd2,        34});
    tbl.push_back('{ALU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    tbl.push_back('{ALU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34});
    tbl.push_back('{ALU_REM,    32'h80000000, 32'd3,        32'hFFFFFFFE, 34});
    tbl.push_back('{ALU_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34});
    tbl.push_back('{ALU_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, 34});
    tbl.push_back('{ALU_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{ALU_REM,    32'd7,        32'd0,        32'd7,        1});
    tbl.push_back('{ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{ALU_REMU,   32'd5,        32'd0,        32'd5,        1});
    tbl.push_back('{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    tbl.push_back('{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1});

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag",    64'(out_tag),    64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);

    // Back-to-back ADD then SRA with in_valid held
    in_valid = 1'b1; in_op = ALU_ADD; in_op1 = 32'd5; in_op2 = 32'd7; in_tag = 5'd1;
    @(posedge clk);
    exp_q.push_back({5'd1, 32'd12});
    #1;
    in_op = ALU_SRA; in_op1 = 32'h80000000; in_op2 = 32'h24; in_tag = 5'd2;
    @(negedge clk);
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    chk("b2b_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    exp_q.push_back({5'd2, 32'hF8000000});
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i), 1'b1, tbl[i].exp);
      if (tbl[i].lat > 1) begin
        chk($sformatf("iter_in_ready_%0d", i), 64'(in_ready), 64'd0);
        chk($sformatf("iter_busy_%0d", i),     64'(busy),     64'd1);
      end
      wait_out($sformatf("latency_%0d", i), tbl[i].lat);
    end
    @(negedge clk);

    // Backpressure on a DIV result
    out_ready = 1'b0;
    send(ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b1, 32'hFFFFFFFD);
    wait_out("bp_div_latency", 34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_div_result",   64'(out_result), 64'hFFFFFFFD);
      chk("bp_div_tag",      64'(out_tag),    64'd9);
      chk("bp_div_in_ready", 64'(in_ready),   64'd0);
      chk("bp_div_valid",    64'(out_valid),  64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_div_drained", 64'(out_valid), 64'd0);

    // Backpressure on a MUL result
    out_ready = 1'b0;
    send(ALU_MUL, 32'hFFFFFFFD, 32'd5, 5'd11, 1'b1, 32'hFFFFFFF1);
    wait_out("bp_mul_latency", 34);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_mul_result", 64'(out_result), 64'hFFFFFFF1);
      chk("bp_mul_busy",   64'(busy),       64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_mul_drained", 64'(out_valid), 64'd0);

    // Flush during DIV iteration
    begin
      int seen = 0;
      send(ALU_DIVU, 32'd100, 32'd7, 5'd3, 1'b0, 32'd0);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready),  64'd1);
      chk("flush_busy",     64'(busy),      64'd0);
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("flush_no_output", 64'(seen), 64'd0);
    end

    // Reset during DIV iteration after a result left out_result non-zero
    send(ALU_ADD, 32'd1, 32'd2, 5'd4, 1'b1, 32'd3);
    wait_out("pre_rst_latency", 1);
    send(ALU_DIV, 32'd100, 32'd7, 5'd6, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid",  64'(out_valid),  64'd0);
    chk("rst2_out_result", 64'(out_result), 64'd0);
    chk("rst2_out_tag",    64'(out_tag),    64'd0);
    chk("rst2_busy",       64'(busy),       64'd0);
    chk("rst2_in_ready",   64'(in_ready),   64'd1);
    repeat (40) @(negedge clk);
    chk("rst2_no_output", 64'(out_valid), 64'd0);

    // Flush coincident with a request drops it
    in_valid = 1'b1; in_op = ALU_ADD; in_op1 = 32'd1; in_op2 = 32'd1; in_tag = 5'd5;
    flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_acc_valid", 64'(out_valid), 64'd0);
    chk("flush_acc_busy",  64'(busy),      64'd0);
    in_valid = 1'b1; in_op = ALU_MUL; in_op1 = 32'd3; in_op2 = 32'd3; in_tag = 5'd12;
    flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_mul_busy",     64'(busy),     64'd0);
    chk("flush_mul_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_mul_no_output", 64'(out_valid), 64'd0);

    // Post-flush operation still works
    send(ALU_SUB, 32'd10, 32'd4, 5'd13, 1'b1, 32'd6);
    wait_out("post_flush_latency", 1);
    @(negedge clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
